booth_wallace_multiplier_seq: RTL and testbench

//  Signed 8x8 -> 16-bit multiplier for the PE datapath.
//  - Radix-4 Booth encoding of B gives 4 partial products of A.
//  - A Wallace (3:2 CSA) tree reduces them; a final carry-propagate adder produces P.
//  - Pipelined: 2 cycles of latency, one new operand pair accepted per cycle.
//  - valid tags each result.
//

---
 rtl/mult_pkg.sv | 44 ++++
 rtl/booth_pp_gen.sv | 34 +++
 rtl/booth_wallace_multiplier_seq.sv | 85 ++++++++
 tb/tb_booth_wallace_multiplier_seq.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types, sizes and arithmetic helpers for the Booth/Wallace multiplier.
package mult_pkg;

  localparam int OP_W   = 8;
  localparam int PROD_W = 16;
  localparam int NUM_PP = 4;

  typedef enum logic [2:0] {
    BS_ZERO,
    BS_POS1,
    BS_POS2,
    BS_NEG1,
    BS_NEG2
  } booth_sel_t;

  typedef struct packed {
    logic [PROD_W-1:0] s;
    logic [PROD_W-1:0] c;
  } csa_t;

  // Radix-4 Booth digit from {b[2i+1], b[2i], b[2i-1]}.
  function automatic booth_sel_t booth_decode(input logic [2:0] bits);
    booth_sel_t sel;
    case (bits)
      3'b001, 3'b010: sel = BS_POS1;
      3'b011:         sel = BS_POS2;
      3'b100:         sel = BS_NEG2;
      3'b101, 3'b110: sel = BS_NEG1;
      default:        sel = BS_ZERO;
    endcase
    return sel;
  endfunction

  // 3:2 carry-save compressor: bitwise full adders, carries moved up one weight.
  function automatic csa_t csa(input logic [PROD_W-1:0] x,
                               input logic [PROD_W-1:0] y,
                               input logic [PROD_W-1:0] z);
    csa_t r;
    r.s = x ^ y ^ z;
    r.c = ((x & y) | (x & z) | (y & z)) << 1;
    return r;
  endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// One Booth partial-product row: selects 0/+-A/+-2A, sign-extends to the
// product width, inverts for negative digits and shifts to weight 4^IDX.
module booth_pp_gen
  import mult_pkg::*;
#(
  parameter int unsigned IDX = 0
) (
  input  logic [2:0]        bits_i,
  input  logic [OP_W-1:0]   a_i,
  output logic [PROD_W-1:0] row_o,
  output logic              neg_o
);

  booth_sel_t        sel;
  logic [PROD_W-1:0] a_ext;
  logic [PROD_W-1:0] mag;

  // Digit select; the +1 of two's-complement negation is returned via neg_o.
  always_comb begin
    sel   = booth_decode(bits_i);
    a_ext = {{(PROD_W-OP_W){a_i[OP_W-1]}}, a_i};
    mag   = '0;
    neg_o = 1'b0;
    case (sel)
      BS_POS1: mag = a_ext;
      BS_POS2: mag = a_ext << 1;
      BS_NEG1: begin mag = a_ext;      neg_o = 1'b1; end
      BS_NEG2: begin mag = a_ext << 1; neg_o = 1'b1; end
      default: mag = '0;
    endcase
    row_o = (neg_o ? ~mag : mag) << (2 * IDX);
  end

endmodule

// File: rtl/booth_wallace_multiplier_seq.sv
// Signed 8x8 -> 16 pipelined multiplier: Booth rows + CSA tree in stage 1,
// carry-propagate add in stage 2. Two-cycle latency, one pair per cycle.
module booth_wallace_multiplier_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] P,
  output logic               valid
);

  if (WIDTH != OP_W) begin : g_width_check
    $error("booth_wallace_multiplier_seq supports WIDTH=8 only");
  end

  logic [OP_W:0]     b_ext;
  logic [PROD_W-1:0] pp_row [NUM_PP];
  logic [NUM_PP-1:0] pp_neg;
  logic [PROD_W-1:0] corr_row;
  csa_t              l1, l2, l3;

  logic [PROD_W-1:0] sum_q, sum_d;
  logic [PROD_W-1:0] carry_q, carry_d;
  logic              v1_q, v1_d;
  logic [PROD_W-1:0] p_q, p_d;
  logic              valid_q, valid_d;

  // Implicit b[-1] = 0 sits at b_ext[0].
  assign b_ext = {B, 1'b0};

  for (genvar i = 0; i < NUM_PP; i++) begin : g_pp
    booth_pp_gen #(.IDX(i)) u_pp (
      .bits_i(b_ext[2*i +: 3]),
      .a_i   (A),
      .row_o (pp_row[i]),
      .neg_o (pp_neg[i])
    );
  end

  // Correction row plus three CSA levels reduce five rows to sum/carry.
  always_comb begin
    corr_row = '0;
    for (int unsigned i = 0; i < NUM_PP; i++) begin
      corr_row[2*i] = pp_neg[i];
    end
    l1 = csa(pp_row[0], pp_row[1], pp_row[2]);
    l2 = csa(l1.s, l1.c, pp_row[3]);
    l3 = csa(l2.s, l2.c, corr_row);
  end

  // Next-state for both stages; data registers hold when their stage is idle.
  always_comb begin
    sum_d   = en ? l3.s : sum_q;
    carry_d = en ? l3.c : carry_q;
    v1_d    = en;
    p_d     = v1_q ? (sum_q + carry_q) : p_q;
    valid_d = v1_q;
  end

  // Pipeline registers, cleared immediately on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_q   <= '0;
      carry_q <= '0;
      v1_q    <= 1'b0;
      p_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
      v1_q    <= v1_d;
      p_q     <= p_d;
      valid_q <= valid_d;
    end
  end

  assign P     = p_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_booth_wallace_multiplier_seq.sv
// Scoreboard bench for booth_wallace_multiplier_seq.
module tb_booth_wallace_multiplier_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [7:0]  A, B;
  logic [15:0] P;
  logic        valid;

  always #5 clk = ~clk;

  booth_wallace_multiplier_seq #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .A    (A),
    .B    (B),
    .P    (P),
    .valid(valid)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  vec_t dir_v [6] = '{
    '{8'd50,  8'd20,  16'h03E8},
    '{8'hF6,  8'd12,  16'hFF88},
    '{8'd100, 8'hFB,  16'hFE0C},
    '{8'h80,  8'hFF,  16'h0080},
    '{8'h7F,  8'h7F,  16'h3F01},
    '{8'h80,  8'h80,  16'h4000}
  };

  vec_t b2b_v [8] = '{
    '{8'd3,   8'd4,   16'h000C},
    '{8'hFF,  8'hFF,  16'h0001},
    '{8'h00,  8'hB3,  16'h0000},
    '{8'h7F,  8'h80,  16'hC080},
    '{8'hFE,  8'h40,  16'hFF80},
    '{8'h0F,  8'h0F,  16'h00E1},
    '{8'hF9,  8'h09,  16'hFFC1},
    '{8'h01,  8'h80,  16'hFF80}
  };

  logic [15:0] exp_q [$];
  logic [15:0] hold_p = '0;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus; expected product is queued for the monitor.
  task automatic drive(input bit e, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] p);
    @(negedge clk);
    en = e;
    A  = a;
    B  = b;
    if (e) exp_q.push_back(p);
  endtask

  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b);
    int ia, ib;
    ia = int'($signed(a));
    ib = int'($signed(b));
    return 16'(ia * ib);
  endfunction

  // Monitor: pops on valid, otherwise checks reset values or a held P.
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        check("reset_P", P, 16'h0000);
        check("reset_valid", {15'b0, valid}, 16'h0000);
        hold_p = '0;
      end else if (valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_result: got P=%h valid=1 expected no result at %0t", P, $time);
        end else begin
          e = exp_q.pop_front();
          check("result_P", P, e);
          hold_p = e;
        end
      end else begin
        check("idle_valid", {15'b0, valid}, 16'h0000);
        check("hold_P", P, hold_p);
      end
    end
  end

  initial begin
    rst = 1'b0;
    en  = 1'b0;
    A   = '0;
    B   = '0;

    // Reset held for two edges with live operands; nothing may be queued.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      en = 1'b1;
      A  = 8'(i * 37 + 5);
      B  = 8'(8'hC3 ^ 8'(i));
    end
    @(posedge clk);
    #2;
    en  = 1'b0;
    rst = 1'b1;

    // Directed values with idle gaps.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, dir_v[i].a, dir_v[i].b, dir_v[i].p);
      drive(1'b0, 8'h00, 8'h00, 16'h0000);
    end

    // Back-to-back issue.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, b2b_v[i].a, b2b_v[i].b, b2b_v[i].p);
    end
    drive(1'b0, 8'h00, 8'h00, 16'h0000);
    drive(1'b0, 8'h00, 8'h00, 16'h0000);

    // Bubble: valid 1,0,1 with P held across the gap.
    drive(1'b1, 8'd3, 8'd4, 16'h000C);
    drive(1'b0, 8'h55, 8'hAA, 16'h0000);
    drive(1'b1, 8'd7, 8'hF9, 16'hFFCF);
    for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 8'h00, 16'h0000);

    // Reset while 5*5 sits in stage 1.
    drive(1'b1, 8'd5, 8'd5, 16'h0019);
    @(posedge clk);
    #2;
    en  = 1'b0;
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("async_reset_P", P, 16'h0000);
    check("async_reset_valid", {15'b0, valid}, 16'h0000);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) drive(1'b0, 8'h00, 8'h00, 16'h0000);

    // Random signed pairs with occasional bubbles.
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] ra, rb;
      bit         re;
      ra = 8'($urandom);
      rb = 8'($urandom);
      re = ($urandom_range(0, 7) != 0);
      drive(re, ra, rb, model(ra, rb));
    end

    // Drain with a bounded wait.
    @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain_remaining", 16'(exp_q.size()), 16'h0000);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
